// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: syncs raw pins, validates 11-bit frames, queues bytes in a FIFO.
// Latency: byte visible on data/ready 3-4 clk after the stop-bit pin edge; data is combinational from the FIFO head.
// Backpressure: consumer pops via ready/nextdata_n; a good frame arriving at a full FIFO is dropped and flags overflow.
// Optional macro PS2_RX_PARITY_CHECK_EN enables odd-parity checking (default: parity bit ignored).
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_BIT = 4'd10;

  // Only the bits that feed the validity check are captured; the parity bit
  // is not stored at all when parity checking is disabled.
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam int FW = 10;
`else
  localparam int FW = 9;
`endif
  localparam logic [3:0] FW_BITS = 4'(FW);

  // ---------------------------------------------------------------------------
  // Pin synchronizers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic ps2_clk_s1, ps2_clk_s2, ps2_clk_d;
  logic ps2_data_s1, ps2_data_s2;
  logic fall;

  // Two-flop synchronizers plus a history flop on clock; reset to idle-high so
  // releasing reset never manufactures a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_s1  <= 1'b1;
      ps2_clk_s2  <= 1'b1;
      ps2_clk_d   <= 1'b1;
      ps2_data_s1 <= 1'b1;
      ps2_data_s2 <= 1'b1;
    end else begin
      ps2_clk_s1  <= ps2_clk;
      ps2_clk_s2  <= ps2_clk_s1;
      ps2_clk_d   <= ps2_clk_s2;
      ps2_data_s1 <= ps2_data;
      ps2_data_s2 <= ps2_data_s1;
    end
  end

  assign fall = ps2_clk_d & ~ps2_clk_s2;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [FW-1:0]   frame;
  logic [TW-1:0]   to_cnt;

  logic            frame_done;
  logic            start_ok;
  logic            stop_ok;
  logic            parity_ok;
  logic            frame_good;
  logic            push_vld;
  logic [7:0]      push_dat;

  // The stop bit is judged live from the synced pin on its own falling edge,
  // so the push lands on the same edge that completes the frame.
  assign frame_done = fall && (state == ST_RECV) && (bit_cnt == LAST_BIT);
  assign start_ok   = ~frame[0];
  assign stop_ok    = ps2_data_s2;
`ifdef PS2_RX_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit carry an odd number of ones.
  assign parity_ok  = ^frame[9:1];
`else
  assign parity_ok  = 1'b1;
`endif
  assign frame_good = start_ok & stop_ok & parity_ok;
  assign push_vld   = frame_done & frame_good;
  assign push_dat   = frame[8:1];

  // Bit collection, frame completion and inactivity timeout; frame_err is a
  // registered one-cycle pulse for completed frames that fail validation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      frame     <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (fall) begin
            frame[0] <= ps2_data_s2;
            bit_cnt  <= 4'd1;
            state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= 4'd0;
              state     <= ST_IDLE;
              frame_err <= ~frame_good;
            end else begin
              if (bit_cnt < FW_BITS) begin
                frame[bit_cnt] <= ps2_data_s2;
              end
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (to_cnt == TO_LIMIT) begin
            // Device went quiet mid-frame: drop the partial frame silently.
            bit_cnt <= 4'd0;
            to_cnt  <= '0;
            state   <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= 4'd0;
          to_cnt  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ready & ~nextdata_n;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push_ok = push_vld & (~full | pop);

  // Storage has no reset; emptiness is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  // Pointer advance and sticky overflow, which clears on the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        overflow <= 1'b0;
      end else if (push_vld && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ready = ~empty;
  // Head is shown only while valid so data reads 0 whenever the FIFO is empty.
  assign data  = ready ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frame reception, latency, draining, overflow, bad frames, timeout, reset.
// Uses default parameters (FIFO_DEPTH=8, TIMEOUT_CYCLES=50000).
// Expectations for bad-parity frames follow PS2_RX_PARITY_CHECK_EN.
module tb_ps2_receiver;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n = 1'b1;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  ps2_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .ready      (ready),
    .nextdata_n (nextdata_n),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Counts cycles with frame_err high, so a stretched pulse shows up too.
  always @(negedge clk) begin
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic flip_par, input logic stop);
    return {stop, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11);
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    logic [10:0] f;
    int          lat;
    int          e0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);

    // 0x1C with latency measured from the stop-bit pin fall
    f = mk(8'h1C, 1'b0, 1'b1);
    send_bits(f, 10);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 0;
    while (!ready && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency_le5", (ready && lat <= 5) ? 32'd1 : 32'd0, 32'd1);
    check("data_1c", data, 8'h1C);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    pop_one();
    check("ready_after_pop", ready, 1'b0);

    // Two bytes, then continuous drain
    send_frame(mk(8'hF0, 1'b0, 1'b1));
    send_frame(mk(8'h1C, 1'b0, 1'b1));
    check("two_ready", ready, 1'b1);
    check("drain_f0", data, 8'hF0);
    nextdata_n = 1'b0;
    @(negedge clk);
    check("drain_1c", data, 8'h1C);
    @(negedge clk);
    check("drain_empty", ready, 1'b0);
    @(negedge clk);
    check("empty_pop_ignored", ready, 1'b0);
    nextdata_n = 1'b1;

    // Overflow: 9 frames into an 8-deep FIFO
    for (int i = 0; i < 8; i++) send_frame(mk(8'h10 + 8'(i), 1'b0, 1'b1));
    check("ovf_before", overflow, 1'b0);
    send_frame(mk(8'h18, 1'b0, 1'b1));
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", data, 8'h10);
    pop_one();
    check("ovf_cleared", overflow, 1'b0);
    nextdata_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("ovf_retained", data, 8'h11 + 8'(i));
      @(negedge clk);
    end
    check("ovf_ninth_lost", ready, 1'b0);
    nextdata_n = 1'b1;

    // Bad parity (0x2A) then bad stop (0x33)
    e0 = err_cnt;
    send_frame(mk(8'h2A, 1'b1, 1'b1));
    send_frame(mk(8'h33, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("bad_err_count", err_cnt - e0, 2);
    check("bad_fifo_empty", ready, 1'b0);
`else
    check("bad_err_count", err_cnt - e0, 1);
    check("bad_ready", ready, 1'b1);
    check("bad_parity_kept", data, 8'h2A);
    pop_one();
    check("bad_fifo_empty", ready, 1'b0);
`endif

    // Timeout discards a partial frame without an error
    e0 = err_cnt;
    send_bits(mk(8'hA5, 1'b0, 1'b1), 5);
    repeat (60000) @(negedge clk);
    send_frame(mk(8'h45, 1'b0, 1'b1));
    check("to_no_err", err_cnt - e0, 0);
    check("to_ready", ready, 1'b1);
    check("to_data_45", data, 8'h45);
    pop_one();
    check("to_empty", ready, 1'b0);

    // Reset mid-frame with a byte queued
    send_frame(mk(8'h5A, 1'b0, 1'b1));
    check("pre_rst_ready", ready, 1'b1);
    send_bits(mk(8'hC3, 1'b0, 1'b1), 6);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    e0 = err_cnt;
    send_frame(mk(8'h77, 1'b0, 1'b1));
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_data", data, 8'h77);
    check("post_rst_no_err", err_cnt - e0, 0);
    pop_one();
    check("post_rst_empty", ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
